// File: rtl/demux4way16_router.sv
// 1-to-4 word router with a 1-entry valid/ready buffer on each output channel.
// Define DEMUX4WAY16_BCAST_EN to add in_bcast, which sends one word to all four channels.
module demux4way16_router #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       sel,
    input  logic             in_valid,
`ifdef DEMUX4WAY16_BCAST_EN
    input  logic             in_bcast,
`endif
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic             out_valid0,
    output logic             out_valid1,
    output logic             out_valid2,
    output logic             out_valid3,
    input  logic             out_ready0,
    input  logic             out_ready1,
    input  logic             out_ready2,
    input  logic             out_ready3
);

    logic [WIDTH-1:0] r_data [4];
    logic [3:0]       r_valid;
    logic [3:0]       w_rdy;
    logic [3:0]       w_open;
    logic [3:0]       w_tgt;
    logic [3:0]       w_load;
    logic             w_bcast;

    assign w_rdy  = {out_ready3, out_ready2, out_ready1, out_ready0};
    // A channel can take a word when empty or when its word leaves this cycle.
    assign w_open = ~r_valid | w_rdy;

`ifdef DEMUX4WAY16_BCAST_EN
    assign w_bcast = in_bcast;
`else
    assign w_bcast = 1'b0;
`endif

    always_comb begin
        w_tgt = 4'b0000;
        if (w_bcast) begin
            w_tgt = 4'b1111;
        end else begin
            w_tgt[sel] = 1'b1;
        end
    end

    assign in_ready = w_bcast ? (&w_open) : w_open[sel];
    assign w_load   = w_tgt & {4{in_valid & in_ready}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_load[k]) begin
                    r_data[k]  <= in_data;
                    r_valid[k] <= 1'b1;
                end else if (r_valid[k] && w_rdy[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign out_data0  = r_data[0];
    assign out_data1  = r_data[1];
    assign out_data2  = r_data[2];
    assign out_data3  = r_data[3];
    assign out_valid0 = r_valid[0];
    assign out_valid1 = r_valid[1];
    assign out_valid2 = r_valid[2];
    assign out_valid3 = r_valid[3];

endmodule

// File: tb/tb_demux4way16_router.sv
// Bench for demux4way16_router: directed vector table, reset corner case,
// then random traffic against a per-channel occupancy model.
module tb_demux4way16_router;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic [1:0]  sel;
    logic        in_valid;
    logic        in_bcast;
    logic        in_ready;
    logic [15:0] out_data0, out_data1, out_data2, out_data3;
    logic        out_valid0, out_valid1, out_valid2, out_valid3;
    logic        out_ready0, out_ready1, out_ready2, out_ready3;

    demux4way16_router #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .sel        (sel),
        .in_valid   (in_valid),
`ifdef DEMUX4WAY16_BCAST_EN
        .in_bcast   (in_bcast),
`endif
        .in_ready   (in_ready),
        .out_data0  (out_data0),
        .out_data1  (out_data1),
        .out_data2  (out_data2),
        .out_data3  (out_data3),
        .out_valid0 (out_valid0),
        .out_valid1 (out_valid1),
        .out_valid2 (out_valid2),
        .out_valid3 (out_valid3),
        .out_ready0 (out_ready0),
        .out_ready1 (out_ready1),
        .out_ready2 (out_ready2),
        .out_ready3 (out_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: each channel either holds a word or is empty.
    bit          m_full [4];
    logic [15:0] m_word [4];

    logic [15:0] w_od [4];
    logic [3:0]  w_ov;
    assign w_od[0] = out_data0;
    assign w_od[1] = out_data1;
    assign w_od[2] = out_data2;
    assign w_od[3] = out_data3;
    assign w_ov = {out_valid3, out_valid2, out_valid1, out_valid0};

    typedef struct {
        logic [15:0] d;
        logic [1:0]  s;
        logic        v;
        logic [3:0]  ord;
        logic        e_rdy;
        logic [3:0]  e_ov;
        logic [1:0]  ch;
        logic [15:0] e_od;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    function automatic logic [3:0] m_valid_vec();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = m_full[k];
        return v;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 4; k++) begin
            m_full[k] = 0;
            m_word[k] = 16'h0;
        end
    endtask

    // Called #1 after a rising edge; leaves time at #1 after the next edge.
    task automatic cyc(input logic [15:0] d, input logic [1:0] s,
                       input logic v, input logic b, input logic [3:0] ord,
                       output logic got_rdy, output logic exp_rdy);
        bit take;
        in_data = d; sel = s; in_valid = v; in_bcast = b;
        {out_ready3, out_ready2, out_ready1, out_ready0} = ord;
        #1;
        got_rdy = in_ready;
        if (b) begin
            exp_rdy = 1'b1;
            for (int k = 0; k < 4; k++)
                if (m_full[k] && !ord[k]) exp_rdy = 1'b0;
        end else begin
            exp_rdy = !m_full[s] || ord[s];
        end
        take = v && exp_rdy;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (take && (b || s == 2'(k))) begin
                m_full[k] = 1;
                m_word[k] = d;
            end else if (m_full[k] && ord[k]) begin
                m_full[k] = 0;
            end
        end
    endtask

    task automatic cmp_model(input string nm);
        chk({nm, "_valid"}, {28'h0, w_ov}, {28'h0, m_valid_vec()});
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_data%0d", nm, k), {16'h0, w_od[k]},
                {16'h0, m_word[k]});
    endtask

    vec_t tbl [$];
    logic g, e;

    initial begin
        rst_n = 1'b0;
        in_data = '0; sel = '0; in_valid = 1'b0; in_bcast = 1'b0;
        {out_ready3, out_ready2, out_ready1, out_ready0} = 4'b0000;
        m_reset();
        #1;
        chk("reset_valid", {28'h0, w_ov}, 32'h0);
        chk("reset_in_ready", {31'h0, in_ready}, 32'h1);
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        tbl.push_back('{16'hA5A5, 2'd2, 1'b1, 4'b0000, 1'b1, 4'b0100, 2'd2, 16'hA5A5});
        tbl.push_back('{16'h0000, 2'd2, 1'b0, 4'b0000, 1'b0, 4'b0100, 2'd2, 16'hA5A5});
        tbl.push_back('{16'h1111, 2'd1, 1'b1, 4'b0000, 1'b1, 4'b0110, 2'd1, 16'h1111});
        tbl.push_back('{16'h1234, 2'd1, 1'b1, 4'b0000, 1'b0, 4'b0110, 2'd1, 16'h1111});
        tbl.push_back('{16'h1234, 2'd1, 1'b1, 4'b0010, 1'b1, 4'b0110, 2'd1, 16'h1234});
        tbl.push_back('{16'h0A0A, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0111, 2'd0, 16'h0A0A});
        tbl.push_back('{16'h00FF, 2'd3, 1'b1, 4'b0000, 1'b1, 4'b1111, 2'd3, 16'h00FF});
        tbl.push_back('{16'h0000, 2'd0, 1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 16'h0A0A});
        for (int i = 0; i < 8; i++)
            tbl.push_back('{16'(i), 2'd0, 1'b1, 4'b0001, 1'b1, 4'b0001, 2'd0, 16'(i)});
        tbl.push_back('{16'h0000, 2'd0, 1'b0, 4'b0001, 1'b1, 4'b0000, 2'd0, 16'h0007});

        foreach (tbl[i]) begin
            cyc(tbl[i].d, tbl[i].s, tbl[i].v, 1'b0, tbl[i].ord, g, e);
            chk($sformatf("vec%0d_in_ready", i), {31'h0, g}, {31'h0, tbl[i].e_rdy});
            chk($sformatf("vec%0d_valid", i), {28'h0, w_ov}, {28'h0, tbl[i].e_ov});
            chk($sformatf("vec%0d_data%0d", i, tbl[i].ch),
                {16'h0, w_od[tbl[i].ch]}, {16'h0, tbl[i].e_od});
        end

        // Fill every channel, then pulse reset between clock edges.
        for (int k = 0; k < 4; k++)
            cyc(16'hC000 + 16'(k), 2'(k), 1'b1, 1'b0, 4'b0000, g, e);
        cmp_model("fill");
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        cmp_model("midreset");
        chk("midreset_in_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        cmp_model("reset_hold");
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(16'h5A5A, 2'd1, 1'b1, 1'b0, 4'b0000, g, e);
        chk("resume_in_ready", {31'h0, g}, {31'h0, e});
        cmp_model("resume");

`ifdef DEMUX4WAY16_BCAST_EN
        cyc(16'h2222, 2'd2, 1'b1, 1'b0, 4'b1011, g, e);
        cyc(16'hBEEF, 2'd0, 1'b1, 1'b1, 4'b1011, g, e);
        chk("bcast_blocked_rdy", {31'h0, g}, 32'h0);
        cyc(16'hBEEF, 2'd0, 1'b1, 1'b1, 4'b1111, g, e);
        chk("bcast_drain_rdy", {31'h0, g}, 32'h1);
        for (int k = 0; k < 4; k++)
            chk($sformatf("bcast_data%0d", k), {16'h0, w_od[k]}, 32'h0000BEEF);
        chk("bcast_valid", {28'h0, w_ov}, 32'hF);
`endif

        for (int i = 0; i < 400; i++) begin
            logic b;
            b = 1'b0;
`ifdef DEMUX4WAY16_BCAST_EN
            b = ($urandom_range(0, 7) == 0);
`endif
            cyc(16'($urandom), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 3) != 0), b,
                4'($urandom), g, e);
            chk($sformatf("rnd%0d_in_ready", i), {31'h0, g}, {31'h0, e});
            cmp_model($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
